// File: rtl/synchronous_counter.sv
// synchronous_counter
//   Synchronous binary up-counter built from a chain of T flip-flops that
//   share one clock. Stage i toggles when the count enable T is high and
//   every lower stage holds 1, so all bits update on the same rising edge.
//
// Parameters:
//   WIDTH    number of counter bits / T flip-flop stages (1..32)
//
// Ports:
//   clk      input          rising-edge clock, sole clock of the block
//   reset_n  input          synchronous clear, ACTIVE-HIGH despite the name
//                           (a 1 clears Q on the next rising edge)
//   T        input          count enable: 1 = increment on next edge, 0 = hold
//   Q        output [W-1:0] current count, driven directly by the flip-flops
//   tc       output         (only with SYNC_COUNTER_TC_EN) terminal count:
//                           T AND Q == all-ones, held low while reset_n = 1;
//                           intended to drive T of a cascaded counter
//
// Build option:
//   SYNC_COUNTER_TC_EN  adds the tc output; when undefined the port is absent.

module synchronous_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             T,
`ifdef SYNC_COUNTER_TC_EN
  output logic             tc,
`endif
  output logic [WIDTH-1:0] Q
);

  // Per-stage toggle enables: ripple AND chain from T through the lower bits.
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign toggle[0] = T;

  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign toggle[i] = toggle[i-1] & q_q[i-1];
  end

  // One T flip-flop per bit; reset takes priority over toggling.
  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    always_comb begin
      q_d[i] = q_q[i] ^ toggle[i];
    end

    always_ff @(posedge clk) begin
      if (reset_n) begin
        q_q[i] <= 1'b0;
      end else begin
        q_q[i] <= q_d[i];
      end
    end
  end

  assign Q = q_q;

`ifdef SYNC_COUNTER_TC_EN
  // The top stage's enable already ANDs T with all lower bits, so adding the
  // top bit gives T AND (Q == all-ones) without a separate reduction.
  assign tc = toggle[WIDTH-1] & q_q[WIDTH-1] & ~reset_n;
`endif

endmodule

// File: tb/tb_synchronous_counter.sv
module tb_synchronous_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset_n;
  logic         T;
  logic [W-1:0] Q;
`ifdef SYNC_COUNTER_TC_EN
  logic         tc;
`endif

  synchronous_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .T       (T),
`ifdef SYNC_COUNTER_TC_EN
    .tc      (tc),
`endif
    .Q       (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         t;
    logic [W-1:0] exp_q;   // Q after the edge
    logic         exp_tc;  // tc before the edge, with these inputs applied
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs away from the edge, check tc before the edge, Q after it.
  task automatic step(input logic rst, input logic t, input logic [W-1:0] exp_q,
                      input logic exp_tc, input string name);
    reset_n = rst;
    T       = t;
    #1;
`ifdef SYNC_COUNTER_TC_EN
    check({name, "_tc"}, {31'd0, tc}, {31'd0, exp_tc});
`endif
    @(posedge clk);
    #1;
    check({name, "_q"}, {28'd0, Q}, {28'd0, exp_q});
  endtask

  task automatic add(input logic rst, input logic t, input int q, input logic tcv);
    vec_t v;
    v.rst = rst; v.t = t; v.exp_q = q[W-1:0]; v.exp_tc = tcv;
    vecs.push_back(v);
  endtask

  // Reference model: plain integer arithmetic on the count.
  int unsigned m;
  int unsigned mod = 1 << W;

  initial begin
    reset_n = 1'b1;
    T       = 1'b1;

    // Reset held two edges with T=1
    add(1, 1, 0, 0);
    add(1, 1, 0, 0);
    // Free count 1..5
    for (int i = 1; i <= 5; i++) add(0, 1, i, 0);
    // Hold at 5 for three edges, then resume
    for (int i = 0; i < 3; i++) add(0, 0, 5, 0);
    add(0, 1, 6, 0);
    // Wrap: reset then 16 counts; tc only before the wrapping edge
    add(1, 1, 0, 0);
    for (int i = 1; i <= 16; i++) add(0, 1, i % 16, (i == 16));
    // Hold at 0 after wrap
    add(0, 0, 0, 0);

    foreach (vecs[k]) step(vecs[k].rst, vecs[k].t, vecs[k].exp_q, vecs[k].exp_tc, "table");

    // Reset mid-count at 9: clears (not 10), then resumes from 0
    step(1, 0, 0, 0, "mid_rst_pre");
    for (int i = 1; i <= 9; i++) step(0, 1, i[W-1:0], 0, "mid_cnt");
    step(1, 1, 0, 0, "mid_rst");
    step(0, 1, 1, 0, "mid_resume");

    // Reset priority at 15 with T=1; tc must stay low while reset is high
    for (int i = 2; i <= 15; i++) step(0, 1, i[W-1:0], 0, "pri_cnt");
    step(0, 0, 15, 0, "pri_hold15");
    step(1, 1, 0, 0, "pri_rst");
    step(1, 1, 0, 0, "pri_rst2");

    // Randomized run against the model
    m = 0;
    for (int n = 0; n < 400; n++) begin
      logic r, t;
      logic etc;
      r = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 3) != 0);
      etc = t && !r && (m == mod - 1);
      if (r) m = 0;
      else if (t) m = (m + 1) % mod;
      step(r, t, m[W-1:0], etc, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synchronous_counter.md
Name: synchronous_counter

Overview:
- Synchronous binary up-counter built structurally from a chain of T flip-flops.
- All stages share one clock.
- Stage i toggles when the count enable T is high and every lower stage is 1.
- Used as a generic event/cycle counter; default width 4 bits (count 0..15, wrap to 0).

Parameters:
- WIDTH, 4, number of counter bits / T flip-flop stages (legal range 1..32).

Ports:
- clk      input   1      rising-edge clock; sole clock of the block
- reset_n  input   1      synchronous, active-high reset (name kept per codebase; a 1 clears the counter on the next rising clk edge)
- T        input   1      count enable; 1 = increment on next edge, 0 = hold
- Q        output  WIDTH  current count value, registered

Behaviour:
- All state changes only on the rising edge of clk; no asynchronous paths.
- Reset: if reset_n = 1 at a rising edge, Q <= 0 (all bits). Reset has priority over T.
- Count: if reset_n = 0 and T = 1 at a rising edge, Q <= Q + 1 modulo 2^WIDTH.
- Hold: if reset_n = 0 and T = 0, Q unchanged.
- Structure:
  - one T flip-flop per bit.
  - Toggle input of bit 0 = T.
  - Toggle input of bit i = T AND Q[0] AND ... AND Q[i-1], generated as a ripple AND chain (combinational), so all bits update on the same edge.
- Latency: Q reflects an increment one clock after T is sampled high; no combinational path from T to Q.
- Wrap-around: from all-ones (15 for WIDTH=4) with T = 1, Q goes to 0 on the next edge; no saturation, no sticky flag.
- Reset mid-count: Q clears on the first edge where reset_n = 1, regardless of T or current value. Counting resumes from 0 on the first edge after reset_n returns to 0.
- Power-up: Q is undefined until the first reset edge. Benches must apply reset before checking values.
- Outputs: Q is driven directly by the flip-flops; glitch-free.

Optional Feature:
- Macro: SYNC_COUNTER_TC_EN
- Defined:
  - Adds output port tc (1 bit, combinational) = T AND (Q == all-ones).
  - tc is high during the cycle in which the next edge will wrap Q to 0.
  - tc is forced to 0 while reset_n = 1.
  - tc is intended for cascading counters: connect it to the T of the next counter.
- Not defined: port tc absent; behaviour otherwise identical.

Test Plan:
- Reset: reset_n = 1 for 2 edges, T = 1 -> Q = 0 after first edge, stays 0 while reset_n = 1.
- Free count: reset_n = 0, T = 1 for 5 edges after reset -> Q = 1,2,3,4,5 on successive edges.
- Hold: Q = 5, T = 0 for 3 edges -> Q stays 5; T = 1 again -> Q = 6 next edge.
- Wrap: count 16 edges from 0 with T = 1 -> Q reaches 15, then 0 on the 16th edge.
  - With SYNC_COUNTER_TC_EN: tc = 1 only while Q = 15 and T = 1.
- Reset mid-operation: Q = 9, T = 1, reset_n = 1 for one edge -> Q = 0 (not 10); reset_n = 0 -> Q = 1 next edge.
- Reset priority: reset_n = 1 and T = 1 together at Q = 15 -> Q = 0.
  - With SYNC_COUNTER_TC_EN: tc = 0 throughout.
